// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command issuer slice.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_pkg;

  localparam int OPW  = 4;
  localparam int SELW = 3;

  localparam logic [SELW-1:0] SEL_ADD = 3'b000;
  localparam logic [SELW-1:0] SEL_SUB = 3'b001;
  localparam logic [SELW-1:0] SEL_AND = 3'b010;
  localparam logic [SELW-1:0] SEL_OR  = 3'b011;
  localparam logic [SELW-1:0] SEL_NOT = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // One queued command: opcode plus both operands.
  typedef struct packed {
    logic [SELW-1:0] sel;
    logic [OPW-1:0]  a;
    logic [OPW-1:0]  b;
  } cmd_t;

  // Opcodes above NOT (101..111) have no ALU meaning.
  function automatic logic sel_illegal(input logic [SELW-1:0] sel);
    return (sel > SEL_NOT);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: circular buffer with registered occupancy count.
// Latency: push visible at head one edge later; head is read combinationally.
// Backpressure: pushes ignored when full, pops ignored when empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  cmd_t                   push_data,
  input  logic                   pop,
  output cmd_t                   head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count < FULL_CNT);
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks push minus pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands, issues them one at a time to an external ALU, holds results.
// Latency: command into an empty idle block -> res_valid two edges after acceptance.
// Backpressure: cmd_ready drops when the FIFO is full; results hold until res_ready.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [OPW-1:0]         cmd_a,
  input  logic [OPW-1:0]         cmd_b,
  input  logic [SELW-1:0]        cmd_sel,
  output logic [OPW-1:0]         alu_a,
  output logic [OPW-1:0]         alu_b,
  output logic [SELW-1:0]        alu_sel,
  input  logic [OPW-1:0]         alu_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [OPW-1:0]         res_data,
  output logic [SELW-1:0]        res_sel,
  output logic                   res_err,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t state;
  state_t state_nxt;
  logic   pop;
  logic   fifo_empty;
  cmd_t   head;
  cmd_t   push_data;

  // Readiness comes from the registered count only: a same-cycle pop never frees a slot.
  assign cmd_ready  = (fifo_count < FULL_CNT);
  assign fifo_empty = (fifo_count == '0);
  assign push_data  = '{sel: cmd_sel, a: cmd_a, b: cmd_b};

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid && cmd_ready),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and pop decision.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = HOLD;
      HOLD: begin
        if (res_ready) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand registers change only when a command leaves the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
    end else if (pop) begin
      alu_a   <= head.a;
      alu_b   <= head.b;
      alu_sel <= head.sel;
    end
  end

  // Capture the ALU result in ISSUE; drop valid once the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_sel   <= '0;
      res_err   <= 1'b0;
    end else if (state == ISSUE) begin
      res_valid <= 1'b1;
      res_sel   <= alu_sel;
      res_err   <= sel_illegal(alu_sel);
      res_data  <= sel_illegal(alu_sel) ? '0 : alu_out;
    end else if (state == HOLD && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule
